isqrt_pipe: RTL



---
 rtl/isqrt_pipe_stage.sv | 68 ++++++
 rtl/isqrt_pipe.sv | 52 +++++
 2 files changed

// File: rtl/isqrt_pipe_stage.sv
// One digit-by-digit square-root iteration and its pipeline registers.
// Produces one result bit per stage; data registers load only on valid.
module isqrt_pipe_stage #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned HW = WIDTH / 2,
  localparam int unsigned RW = WIDTH / 2 + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_i,
  input  logic [RW-1:0]    rem_i,
  input  logic [HW-1:0]    root_i,
  input  logic [WIDTH-1:0] arg_i,
  output logic             vld_o,
  output logic [RW-1:0]    rem_o,
  output logic [HW-1:0]    root_o,
  output logic [WIDTH-1:0] arg_o
);

  logic             vld_q;
  logic [RW-1:0]    rem_q, rem_d;
  logic [HW-1:0]    root_q, root_d;
  logic [WIDTH-1:0] arg_q, arg_d;

  logic [RW+1:0] shf;
  logic [RW+1:0] trial;
  logic [RW+1:0] diff;
  logic          ge;
  logic          unused;

  // Bring down the next two argument bits and try to set the next root bit.
  always_comb begin
    shf    = {rem_i, arg_i[WIDTH-1:WIDTH-2]};
    trial  = {2'b00, root_i, 2'b01};
    diff   = shf - trial;
    ge     = (shf >= trial);
    rem_d  = ge ? diff[RW-1:0] : shf[RW-1:0];
    root_d = {root_i[HW-2:0], ge};
    arg_d  = {arg_i[WIDTH-3:0], 2'b00};
  end

  // The top remainder bits never carry weight: rem stays <= 2*root+1.
  assign unused = ^{shf[RW+1:RW], diff[RW+1:RW]};

  // Valid travels every cycle and is cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_i;
    end
  end

  // Data only moves with a valid argument, so bubbles leave it frozen.
  always_ff @(posedge clk) begin
    if (vld_i) begin
      rem_q  <= rem_d;
      root_q <= root_d;
      arg_q  <= arg_d;
    end
  end

  assign vld_o  = vld_q;
  assign rem_o  = rem_q;
  assign root_o = root_q;
  assign arg_o  = arg_q;

endmodule

// File: rtl/isqrt_pipe.sv
// Fully pipelined integer square root, y = floor(sqrt(x)).
// One argument per cycle, WIDTH/2 stages, results in arrival order.
module isqrt_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x_vld,
  input  logic [WIDTH-1:0]   x,
  output logic               y_vld,
  output logic [WIDTH/2-1:0] y
);

  localparam int unsigned LATENCY = WIDTH / 2;
  localparam int unsigned HW      = WIDTH / 2;
  localparam int unsigned RW      = WIDTH / 2 + 2;

  logic             vld_w  [LATENCY+1];
  logic [RW-1:0]    rem_w  [LATENCY+1];
  logic [HW-1:0]    root_w [LATENCY+1];
  logic [WIDTH-1:0] arg_w  [LATENCY+1];
  logic             unused;

  assign vld_w[0]  = x_vld;
  assign rem_w[0]  = '0;
  assign root_w[0] = '0;
  assign arg_w[0]  = x;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    isqrt_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (vld_w[i]),
      .rem_i  (rem_w[i]),
      .root_i (root_w[i]),
      .arg_i  (arg_w[i]),
      .vld_o  (vld_w[i+1]),
      .rem_o  (rem_w[i+1]),
      .root_o (root_w[i+1]),
      .arg_o  (arg_w[i+1])
    );
  end

  // The final remainder and exhausted argument are not needed downstream.
  assign unused = ^{rem_w[LATENCY], arg_w[LATENCY]};

  assign y_vld = vld_w[LATENCY];
  assign y     = root_w[LATENCY];

endmodule
